// File: rtl/icache_dcache_axi_read_arbiter.sv
// icache_dcache_axi_read_arbiter: shares one AXI3 read channel between I-cache and D-cache line refills (define ICACHE_DCACHE_ARB_RR_EN for round-robin ties)
module icache_dcache_axi_read_arbiter #(
    parameter int DATA_LENGTH = 32,
    parameter int LINE_SIZE = 64,
    parameter logic [3:0] IC_ID = 4'd0,
    parameter logic [3:0] DC_ID = 4'd1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ic_req,
    input  logic [31:0]            ic_addr,
    output logic                   ic_gnt,
    output logic                   ic_rvalid,
    output logic [DATA_LENGTH-1:0] ic_rdata,
    output logic                   ic_rlast,
    input  logic                   dc_req,
    input  logic [31:0]            dc_addr,
    output logic                   dc_gnt,
    output logic                   dc_rvalid,
    output logic [DATA_LENGTH-1:0] dc_rdata,
    output logic                   dc_rlast,
    output logic [31:0]            ARADDR,
    output logic [3:0]             ARLEN,
    output logic [2:0]             ARSIZE,
    output logic [1:0]             ARBURST,
    output logic [3:0]             ARID,
    output logic                   ARVALID,
    input  logic                   ARREADY,
    input  logic [DATA_LENGTH-1:0] RDATA,
    input  logic                   RVALID,
    input  logic                   RLAST,
    input  logic [3:0]             RID,
    output logic                   RREADY,
    output logic                   err
);
    localparam int BEATS = LINE_SIZE / (DATA_LENGTH / 8);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t state, state_nxt;
    logic owner;
    logic [4:0] cnt;
    logic start, win_dc, beat, bad;

    assign start = state == IDLE && (ic_req || dc_req);
    assign beat = state == DATA && RVALID;
    assign bad = RID != ARID || (RLAST ? cnt + 5'd1 != 5'(BEATS) : cnt >= 5'(BEATS));

`ifdef ICACHE_DCACHE_ARB_RR_EN
    logic last_dc;

    assign win_dc = dc_req && (!ic_req || !last_dc);

    // remember the last winner so the next tie goes the other way
    always_ff @(posedge clk) begin
        if (rst) last_dc <= 1'b1;
        else if (start) last_dc <= win_dc;
    end
`else
    assign win_dc = dc_req && !ic_req;
`endif

    assign ARLEN = 4'(BEATS - 1);
    assign ARSIZE = 3'($clog2(DATA_LENGTH / 8));
    assign ARBURST = 2'b01;
    assign ARVALID = state == ADDR;
    assign RREADY = state == DATA;
    assign ic_gnt = state != IDLE && !owner;
    assign dc_gnt = state != IDLE && owner;
    assign ic_rvalid = beat && !owner;
    assign dc_rvalid = beat && owner;
    assign ic_rlast = ic_rvalid && RLAST;
    assign dc_rlast = dc_rvalid && RLAST;
    assign ic_rdata = RDATA;
    assign dc_rdata = RDATA;

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nxt;
    end

    // next state: only RLAST closes a burst, whatever the beat count
    always_comb begin
        state_nxt = state;
        if (start) state_nxt = ADDR;
        if (state == ADDR && ARREADY) state_nxt = DATA;
        if (beat && RLAST) state_nxt = IDLE;
    end

    // winner capture, beat counting and error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            owner <= 1'b0;
            ARADDR <= '0;
            ARID <= '0;
            cnt <= '0;
            err <= 1'b0;
        end else begin
            err <= beat && bad;
            if (start) begin
                owner <= win_dc;
                ARADDR <= (win_dc ? dc_addr : ic_addr) & ~32'(LINE_SIZE - 1);
                ARID <= win_dc ? DC_ID : IC_ID;
            end
            if (ARVALID && ARREADY) cnt <= '0;
            if (beat) cnt <= cnt + 5'd1;
        end
    end
endmodule

// File: tb/tb_icache_dcache_axi_read_arbiter.sv
// tb_icache_dcache_axi_read_arbiter: randomized scoreboard bench with an AXI read slave and a transaction-level model
module tb_icache_dcache_axi_read_arbiter;
    localparam int BEATS = 16;
`ifdef ICACHE_DCACHE_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 0, rst = 1;
    logic ic_req = 0, dc_req = 0;
    logic [31:0] ic_addr = 0, dc_addr = 0;
    logic ic_gnt, dc_gnt, ic_rvalid, dc_rvalid, ic_rlast, dc_rlast;
    logic [31:0] ic_rdata, dc_rdata, ARADDR;
    logic [3:0] ARLEN, ARID;
    logic [2:0] ARSIZE;
    logic [1:0] ARBURST;
    logic ARVALID, ARREADY = 0, RVALID = 0, RLAST = 0, RREADY, err;
    logic [31:0] RDATA = 0;
    logic [3:0] RID = 0;

    icache_dcache_axi_read_arbiter dut (
        .clk(clk), .rst(rst),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_gnt(ic_gnt), .ic_rvalid(ic_rvalid), .ic_rdata(ic_rdata), .ic_rlast(ic_rlast),
        .dc_req(dc_req), .dc_addr(dc_addr), .dc_gnt(dc_gnt), .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata), .dc_rlast(dc_rlast),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARID(ARID), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RVALID(RVALID), .RLAST(RLAST), .RID(RID), .RREADY(RREADY), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [31:0] a; logic [3:0] id;} ar_t;
    typedef struct packed {bit w; logic [31:0] d; bit l; bit e;} beat_t;
    ar_t aq[$];
    beat_t bq[$];
    ar_t am;
    beat_t bm;
    int cmp = 0, mism = 0;
    bit mon_on = 0, exp_err = 0, last_dc = 1;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        cmp++;
        if (a !== e) begin
            mism++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    // monitor: pops expected AR and R transfers whenever the DUT presents them
    always @(negedge clk) if (mon_on) begin
        chk("err", err, exp_err);
        exp_err = 0;
        if (ARVALID && ARREADY) begin
            if (aq.size() == 0) chk("ar_unexpected", 1, 0);
            else begin
                am = aq.pop_front();
                chk("araddr", ARADDR, am.a);
                chk("arid", ARID, am.id);
                chk("arlen", ARLEN, BEATS - 1);
                chk("arsize", ARSIZE, 2);
                chk("arburst", ARBURST, 1);
            end
        end
        if (ic_rvalid || dc_rvalid) begin
            if (bq.size() == 0) chk("beat_unexpected", 1, 0);
            else begin
                bm = bq.pop_front();
                chk("rvalid", {ic_rvalid, dc_rvalid}, bm.w ? 2'b01 : 2'b10);
                chk("rdata", bm.w ? dc_rdata : ic_rdata, bm.d);
                chk("rlast", {ic_rlast, dc_rlast}, bm.l ? (bm.w ? 2'b01 : 2'b10) : 2'b00);
                exp_err = bm.e && !rst;
            end
        end
    end

    // one request/burst; the model picks the winner from the arbitration rule, g returns the DUT's D-cache grant
    task automatic burst(input bit ir, input bit dr, input bit hold, input int ard, input int nb,
                         input int bad, input int rst_at, input bit seq, output bit g);
        bit w;
        logic [31:0] ea;
        logic [3:0] eid;
        ic_req = ir; dc_req = dr;
        ic_addr = $urandom; dc_addr = $urandom;
        w = (ir && dr) ? (RR ? !last_dc : 1'b0) : dr;
        last_dc = w;
        ea = (w ? dc_addr : ic_addr) & 32'hFFFF_FFC0;
        eid = w ? 4'd1 : 4'd0;
        aq.push_back({ea, eid});
        @(posedge clk); #1;
        g = dc_gnt;
        chk("gnt", {ic_gnt, dc_gnt}, w ? 2'b01 : 2'b10);
        chk("arvalid_up", ARVALID, 1);
        if (!hold) begin ic_req = 0; dc_req = 0; end
        repeat (ard) begin
            @(posedge clk); #1;
            chk("arvalid_hold", ARVALID, 1);
            chk("araddr_stable", ARADDR, ea);
            chk("rready_low", RREADY, 0);
        end
        ARREADY = 1;
        @(posedge clk); #1;
        ARREADY = 0;
        chk("arvalid_down", ARVALID, 0);
        chk("rready_up", RREADY, 1);
        for (int i = 0; i < nb; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                RVALID = 0;
                @(posedge clk); #1;
            end
            if (i == rst_at) begin
                RVALID = 0; rst = 1;
                @(posedge clk); #1;
                rst = 0; last_dc = 1;
                chk("rst_arvalid", ARVALID, 0);
                chk("rst_rready", RREADY, 0);
                chk("rst_gnt", {ic_gnt, dc_gnt}, 0);
                chk("rst_err", err, 0);
                return;
            end
            RVALID = 1;
            RDATA = seq ? 32'(i) : $urandom;
            RID = (i == bad) ? 4'd5 : eid;
            RLAST = (i == nb - 1);
            bq.push_back({w, RDATA, RLAST, (RID != eid) || (RLAST ? (i + 1 != BEATS) : (i >= BEATS))});
            @(posedge clk); #1;
        end
        RVALID = 0; RLAST = 0;
        chk("gnt_fall", {ic_gnt, dc_gnt}, 0);
    endtask

    initial begin
        bit g;
        int r, nb;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        chk("rst_arvalid0", ARVALID, 0);
        chk("rst_rready0", RREADY, 0);
        chk("rst_gnt0", {ic_gnt, dc_gnt}, 0);
        chk("rst_rvalid0", {ic_rvalid, dc_rvalid, ic_rlast, dc_rlast}, 0);
        chk("rst_araddr0", ARADDR, 0);
        chk("rst_arid0", ARID, 0);
        chk("rst_err0", err, 0);
        chk("rst_arlen0", ARLEN, 15);
        mon_on = 1;
        for (int k = 0; k < 3; k++) begin
            burst(1, 1, 1, 0, BEATS, -1, -1, 0, g);
            chk("tie_order", g, RR ? k % 2 : 0);
        end
        burst(1, 0, 0, 0, BEATS, -1, -1, 1, g);
        burst(0, 1, 0, 5, BEATS, -1, -1, 0, g);
        burst(1, 0, 0, 0, 8, -1, -1, 0, g);
        burst(0, 1, 0, 1, BEATS, -1, -1, 0, g);
        burst(0, 1, 0, 0, BEATS, 3, -1, 0, g);
        burst(1, 0, 0, 0, 18, -1, -1, 0, g);
        burst(1, 0, 0, 2, BEATS, -1, 6, 0, g);
        burst(1, 0, 0, 0, BEATS, -1, -1, 1, g);
        for (int k = 0; k < 30; k++) begin
            r = $urandom_range(1, 3);
            nb = $urandom_range(0, 9);
            nb = nb == 0 ? 12 : nb == 1 ? 18 : BEATS;
            burst(r[0], r[1], 1'($urandom_range(0, 1)), $urandom_range(0, 3), nb,
                  $urandom_range(0, 9) == 0 ? $urandom_range(0, nb - 1) : -1, -1, 0, g);
        end
        ic_req = 0; dc_req = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("ar_q_empty", aq.size(), 0);
        chk("beat_q_empty", bq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
        $finish;
    end
endmodule
